// File: rtl/adder_pkg.sv
// Shared types and helpers for the multi-cycle slice adder: FSM encoding,
// slice-count/index-width arithmetic and the signed-overflow rule.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned nslice_f(input int unsigned width, input int unsigned slice);
    return width / slice;
  endfunction

  // Index register needs at least one bit even when a single slice covers the word.
  function automatic int unsigned idx_width_f(input int unsigned nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

  function automatic logic overflow_f(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/slice_rca.sv
// Combinational W-bit ripple-carry adder; the multi-cycle adder reuses one
// instance for every slice.
module slice_rca #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  always_comb begin : ripple
    logic c;
    c = cin;
    s = '0;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/multicycle_slice_adder.sv
// Adds or subtracts two WIDTH-bit operands one SLICE-bit slice per clock,
// LSB slice first, with valid/ready handshakes on both sides.
module multicycle_slice_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned NSLICE = nslice_f(WIDTH, SLICE);
  localparam int unsigned IDX_W  = idx_width_f(NSLICE);
  localparam int unsigned OFF_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if ((WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("multicycle_slice_adder: SLICE (%0d) must divide WIDTH (%0d)", SLICE, WIDTH);
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [OFF_W-1:0]   off_c;
  logic [SLICE-1:0]   slice_s_c;
  logic               slice_cout_c;

  assign off_c = OFF_W'(idx_q * SLICE);

  // Single adder time-multiplexed across slices by the index.
  slice_rca #(.W(SLICE)) u_rca (
    .a    (a_q[off_c +: SLICE]),
    .b    (b_q[off_c +: SLICE]),
    .cin  (carry_q),
    .s    (slice_s_c),
    .cout (slice_cout_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_RUN;
      ST_RUN:  if (idx_q == LAST_IDX) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered handshake outputs follow the next state.
  always_comb begin
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub | carry_in;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        sum_d[off_c +: SLICE] = slice_s_c;
        carry_d               = slice_cout_c;
        idx_d                 = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d = slice_cout_c;
          ovf_d  = overflow_f(a_q[WIDTH-1], b_q[WIDTH-1], slice_s_c[SLICE-1]);
        end
      end
      default: ;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_multicycle_slice_adder.sv
// Self-checking bench: directed vectors, backpressure and reset corner cases on a
// 64/16 instance, plus randomized sweeps over other WIDTH/SLICE configurations.
module tb_multicycle_slice_adder;

  localparam int W       = 64;
  localparam int S       = 16;
  localparam int NS      = W / S;
  localparam int TMO     = 50;
  localparam int N_RAND  = 200;
  localparam int N_SWEEP = 1000;

  typedef struct packed {
    logic [63:0] s;
    logic        co;
    logic        ov;
  } res_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic        cin;
    logic [63:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  logic clk;
  logic rst_n;
  logic rst_sw_n;
  int   n_cmp = 0;
  int   n_err = 0;

  logic          in_valid, in_ready, sub, carry_in, out_valid, out_ready, carry_out, overflow;
  logic [W-1:0]  a, b, sum;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  multicycle_slice_adder #(.WIDTH(W), .SLICE(S)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: unsigned sum for sum/carry, true signed arithmetic range for overflow.
  function automatic res_t model(input logic [63:0] ma, input logic [63:0] mb,
                                 input logic msub, input logic mcin, input int w);
    logic [127:0]        mask, ua, ub, u;
    logic signed [127:0] sa, sb, r, lim;
    res_t                res;
    mask = (128'(1) << w) - 128'(1);
    ua   = {64'b0, ma} & mask;
    ub   = {64'b0, mb} & mask;
    u    = msub ? (ua + ((~ub) & mask) + 128'(1)) : (ua + ub + 128'(mcin));
    sa   = $signed(ua);
    sb   = $signed(ub);
    if ((ua >> (w - 1)) != '0) sa = sa - $signed(128'(1) << w);
    if ((ub >> (w - 1)) != '0) sb = sb - $signed(128'(1) << w);
    r    = msub ? (sa - sb) : (sa + sb + $signed(128'(mcin)));
    lim  = $signed(128'(1) << (w - 1));
    res.s  = 64'(u & mask);
    res.co = ((u >> w) != '0);
    res.ov = (r >= lim) || (r < -lim);
    return res;
  endfunction

  task automatic send(input logic [63:0] ta, input logic [63:0] tb2, input logic ts, input logic tc);
    int cnt = 0;
    while (in_ready !== 1'b1 && cnt < TMO) begin
      @(negedge clk);
      cnt++;
    end
    check("accept_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; a = ta; b = tb2; sub = ts; carry_in = tc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = {$urandom(), $urandom()};
    b        = {$urandom(), $urandom()};
    sub      = 1'($urandom());
    carry_in = 1'($urandom());
  endtask

  task automatic wait_result(input string name);
    int lat = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(NS));
  endtask

  task automatic check_res(input string name, input logic [63:0] es, input logic eco, input logic eov);
    check({name, "_sum"}, sum, es);
    check({name, "_carry_out"}, 64'(carry_out), 64'(eco));
    check({name, "_overflow"}, 64'(overflow), 64'(eov));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("valid_drop", 64'(out_valid), 64'd0);
    check("ready_back", 64'(in_ready), 64'd1);
  endtask

  // Randomized sweeps over other slice geometries, each with its own instance.
  for (genvar k = 0; k < 3; k++) begin : g_sw
    localparam int SW  = (k == 2) ? 32 : 64;
    localparam int SS  = (k == 0) ? 64 : ((k == 1) ? 8 : 4);
    localparam int SNS = SW / SS;

    logic          iv, ir, sb, ci, ovld, ordy, co, ovf;
    logic [SW-1:0] ta, tbv, ts;
    bit            done = 1'b0;

    multicycle_slice_adder #(.WIDTH(SW), .SLICE(SS)) u_dut (
      .clk       (clk),
      .rst_n     (rst_sw_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (ta),
      .b         (tbv),
      .sub       (sb),
      .carry_in  (ci),
      .out_valid (ovld),
      .out_ready (ordy),
      .sum       (ts),
      .carry_out (co),
      .overflow  (ovf)
    );

    initial begin
      logic [63:0] mask, ra, rb;
      logic        rs, rc;
      res_t        e;
      int          cnt, lat, pick;
      iv = 1'b0; sb = 1'b0; ci = 1'b0; ordy = 1'b0; ta = '0; tbv = '0;
      mask = {64{1'b1}} >> (64 - SW);
      wait (rst_sw_n === 1'b1);
      @(negedge clk);
      for (int n = 0; n < N_SWEEP; n++) begin
        ra   = {$urandom(), $urandom()} & mask;
        rb   = {$urandom(), $urandom()} & mask;
        pick = $urandom_range(0, 7);
        if (pick == 0) ra = mask;
        if (pick == 1) rb = ~ra & mask;
        rs = 1'($urandom());
        rc = 1'($urandom());
        cnt = 0;
        while (ir !== 1'b1 && cnt < TMO) begin
          @(negedge clk);
          cnt++;
        end
        check($sformatf("sw%0d_ready", k), 64'(ir), 64'd1);
        iv = 1'b1; ta = SW'(ra); tbv = SW'(rb); sb = rs; ci = rc;
        @(posedge clk);
        #1;
        iv = 1'b0; ta = SW'({$urandom(), $urandom()}); tbv = SW'({$urandom(), $urandom()});
        lat = 0;
        @(negedge clk);
        while (ovld !== 1'b1 && lat < TMO) begin
          @(negedge clk);
          lat++;
        end
        check($sformatf("sw%0d_latency", k), 64'(lat), 64'(SNS));
        e = model(ra, rb, rs, rc, SW);
        check($sformatf("sw%0d_sum a=%h b=%h sub=%b", k, ra, rb, rs), 64'(ts), e.s);
        check($sformatf("sw%0d_carry_out", k), 64'(co), 64'(e.co));
        check($sformatf("sw%0d_overflow", k), 64'(ovf), 64'(e.ov));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        ordy = 1'b1;
        @(posedge clk);
        #1;
        ordy = 1'b0;
        @(negedge clk);
        check($sformatf("sw%0d_valid_drop", k), 64'(ovld), 64'd0);
      end
      done = 1'b1;
    end
  end

  initial begin
    vec_t        vecs[9];
    res_t        e;
    logic [63:0] ra, rb;
    logic        rs, rc;
    int          cyc, seen;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[1] = '{64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[4] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[5] = '{64'd7, 64'd7, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[7] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
                64'h2222_2222_2222_2211, 1'b0, 1'b0};
    vecs[8] = '{64'h0, 64'd1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};

    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; carry_in = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0; rst_sw_n = 1'b0;
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_flags", 64'({carry_out, overflow}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; rst_sw_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);

    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
      wait_result($sformatf("vec%0d", i));
      check_res($sformatf("vec%0d", i), vecs[i].s, vecs[i].co, vecs[i].ov);
      release_out();
    end

    // Backpressure: result held while new operands are presented and ignored.
    send(64'd3, 64'd4, 1'b0, 1'b0);
    wait_result("bp");
    check_res("bp", 64'd7, 1'b0, 1'b0);
    in_valid = 1'b1; a = 64'd100; b = 64'd1; sub = 1'b1; carry_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_sum", sum, 64'd7);
      check("bp_hold_flags", 64'({out_valid, in_ready, carry_out, overflow}), 64'b1000);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_valid_drop", 64'(out_valid), 64'd0);
    check("bp_ready_back", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result("bp_next");
    check_res("bp_next", 64'd99, 1'b1, 1'b0);
    release_out();

    // Reset two cycles into an operation aborts it.
    send(64'h1111, 64'h2222, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sum", sum, 64'd0);
    check("mid_rst_flags", 64'({out_valid, in_ready, carry_out, overflow}), 64'd0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    check("mid_rst_no_valid", 64'(seen), 64'd0);
    rst_n = 1'b1;
    send(64'd3, 64'd4, 1'b0, 1'b0);
    wait_result("after_rst");
    check_res("after_rst", 64'd7, 1'b0, 1'b0);
    release_out();

    for (int n = 0; n < N_RAND; n++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) rb = ~ra;
      rs = 1'($urandom());
      rc = 1'($urandom());
      send(ra, rb, rs, rc);
      wait_result("rand");
      e = model(ra, rb, rs, rc, W);
      check_res($sformatf("rand a=%h b=%h sub=%b cin=%b", ra, rb, rs, rc), e.s, e.co, e.ov);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_out();
    end

    cyc = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
    check("sweep_complete", 64'({g_sw[0].done, g_sw[1].done, g_sw[2].done}), 64'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
